// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port (CPU / loader) arbiter in front of a word RAM.
// Round-robin on conflict, IDLE/ACCESS/RESP handshake with range errors.
module ram_arbiter #(
  parameter int RAM_SIZE = 16,
  parameter int ADDR_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [31:0]           wdata_a,
  output logic                  ack_a,
  output logic                  err_a,
  output logic [31:0]           rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_W-1:0]     addr_b,
  input  logic [31:0]           wdata_b,
  output logic                  ack_b,
  output logic                  err_b,
  output logic [31:0]           rdata_b,
  output logic                  busy,
  output logic [RAM_SIZE*32-1:0] ram_flat
);

  localparam int IW = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [31:0]       mem [RAM_SIZE];
  logic              win_b;
  logic              lwe;
  logic              last_b;
  logic [ADDR_W-1:0] laddr;
  logic [31:0]       lwdata;
  logic              grant;
  logic              pick_b;
  logic              inr;
  logic [IW-1:0]     idx;

  assign busy = (state_q != IDLE);
  assign inr  = (32'(laddr) < 32'(RAM_SIZE));
  assign idx  = laddr[IW-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and grant decision; B wins a tie only if A went last
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    pick_b  = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant  = req_a | req_b;
        pick_b = req_b & (~req_a | ~last_b);
        if (grant) state_d = ACCESS;
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner, perform the access and pulse ack/err for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_a   <= 1'b0;
      ack_b   <= 1'b0;
      err_a   <= 1'b0;
      err_b   <= 1'b0;
      rdata_a <= '0;
      rdata_b <= '0;
      last_b  <= 1'b1;
      win_b   <= 1'b0;
      lwe     <= 1'b0;
      laddr   <= '0;
      lwdata  <= '0;
      for (int i = 0; i < RAM_SIZE; i++) mem[i] <= '0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      err_a <= 1'b0;
      err_b <= 1'b0;
      if (grant) begin
        win_b  <= pick_b;
        last_b <= pick_b;
        lwe    <= pick_b ? we_b : we_a;
        laddr  <= pick_b ? addr_b : addr_a;
        lwdata <= pick_b ? wdata_b : wdata_a;
      end
      if (state_q == ACCESS) begin
        if (win_b) begin
          ack_b <= 1'b1;
          err_b <= ~inr;
        end else begin
          ack_a <= 1'b1;
          err_a <= ~inr;
        end
        if (lwe) begin
          if (inr) mem[idx] <= lwdata;
        end else if (win_b) begin
          rdata_b <= inr ? mem[idx] : '0;
        end else begin
          rdata_a <= inr ? mem[idx] : '0;
        end
      end
    end
  end

  // Flat RAM image, word i at bits [(i+1)*32-1 -: 32]
  for (genvar g = 0; g < RAM_SIZE; g++) begin : g_flat
    assign ram_flat[g*32 +: 32] = mem[g];
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed plus random accesses against a
// behavioural RAM / round-robin model.
module tb_ram_arbiter;

  localparam int RS = 16;
  localparam int AW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_a, we_a, req_b, we_b;
  logic [AW-1:0]    addr_a, addr_b;
  logic [31:0]      wdata_a, wdata_b;
  logic             ack_a, err_a, ack_b, err_b, busy;
  logic [31:0]      rdata_a, rdata_b;
  logic [RS*32-1:0] ram_flat;

  ram_arbiter #(.RAM_SIZE(RS), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .err_a(err_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .err_b(err_b), .rdata_b(rdata_b),
    .busy(busy), .ram_flat(ram_flat)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem_m [RS];
  logic [31:0] rd_m  [2];
  bit          last_b_m;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [RS*32-1:0] obs,
                      input logic [RS*32-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [RS*32-1:0] image();
    logic [RS*32-1:0] v;
    for (int i = 0; i < RS; i++) v[i*32 +: 32] = mem_m[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < RS; i++) mem_m[i] = '0;
    rd_m[0]  = '0;
    rd_m[1]  = '0;
    last_b_m = 1'b1;
  endfunction

  // Apply one completed access to the model; returns expected err
  function automatic bit model_do(input bit p, input bit we,
                                  input logic [AW-1:0] a,
                                  input logic [31:0] d);
    bit ok;
    ok = (int'(a) < RS);
    if (we && ok) mem_m[a[3:0]] = d;
    if (!we) rd_m[p] = ok ? mem_m[a[3:0]] : 32'h0;
    last_b_m = p;
    return !ok;
  endfunction

  task automatic set_port(input bit p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [31:0] d);
    if (p) begin
      req_b = r; we_b = w; addr_b = a; wdata_b = d;
    end else begin
      req_a = r; we_a = w; addr_a = a; wdata_a = d;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "/ack_a"}, ack_a, 1'b0);
    chk1({tag, "/ack_b"}, ack_b, 1'b0);
    chk1({tag, "/err_a"}, err_a, 1'b0);
    chk1({tag, "/err_b"}, err_b, 1'b0);
    chk1({tag, "/busy"}, busy, 1'b0);
    chk32({tag, "/rdata_a"}, rdata_a, 32'h0);
    chk32({tag, "/rdata_b"}, rdata_b, 32'h0);
    chkw({tag, "/ram"}, ram_flat, '0);
  endtask

  // Single-port access: started in IDLE, ends one IDLE cycle after ack
  task automatic access(input string tag, input bit p, input bit we,
                        input logic [AW-1:0] a, input logic [31:0] d);
    int c;
    bit e;
    logic ap;
    set_port(p, 1'b1, we, a, d);
    c  = 0;
    ap = 1'b0;
    while (!ap && c < 8) begin
      @(negedge clk);
      c++;
      ap = p ? ack_b : ack_a;
      chk1({tag, "/other_ack"}, p ? ack_a : ack_b, 1'b0);
      chk1({tag, "/other_err"}, p ? err_a : err_b, 1'b0);
      if (c == 1) chk1({tag, "/busy"}, busy, 1'b1);
    end
    chk32({tag, "/latency"}, c, 32'd2);
    e = model_do(p, we, a, d);
    chk1({tag, "/err"}, p ? err_b : err_a, e);
    chk32({tag, "/rdata_a"}, rdata_a, rd_m[0]);
    chk32({tag, "/rdata_b"}, rdata_b, rd_m[1]);
    chkw({tag, "/ram"}, ram_flat, image());
    set_port(p, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk1({tag, "/idle_busy"}, busy, 1'b0);
    chk1({tag, "/idle_ack"}, ack_a | ack_b, 1'b0);
  endtask

  // Both ports request in the same IDLE cycle and hold until acked
  task automatic pair(input string tag,
                      input bit wa, input logic [AW-1:0] aa,
                      input logic [31:0] da,
                      input bit wb, input logic [AW-1:0] ab,
                      input logic [31:0] db);
    int cyc [2];
    bit first;
    bit e;
    first = last_b_m ? 1'b0 : 1'b1;
    cyc[0] = 0;
    cyc[1] = 0;
    set_port(1'b0, 1'b1, wa, aa, da);
    set_port(1'b1, 1'b1, wb, ab, db);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk1({tag, "/both_ack"}, ack_a & ack_b, 1'b0);
      if (ack_a && cyc[0] == 0) begin
        cyc[0] = c;
        e = model_do(1'b0, wa, aa, da);
        chk1({tag, "/err_a"}, err_a, e);
        chk32({tag, "/rdata_a"}, rdata_a, rd_m[0]);
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
      end
      if (ack_b && cyc[1] == 0) begin
        cyc[1] = c;
        e = model_do(1'b1, wb, ab, db);
        chk1({tag, "/err_b"}, err_b, e);
        chk32({tag, "/rdata_b"}, rdata_b, rd_m[1]);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
      end
      if (cyc[0] != 0 && cyc[1] != 0) break;
    end
    chk32({tag, "/first_cyc"}, cyc[first], 32'd2);
    chk32({tag, "/second_cyc"}, cyc[!first], 32'd5);
    chkw({tag, "/ram"}, ram_flat, image());
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk1({tag, "/idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_zero("reset");

    access("b_wr3", 1'b1, 1'b1, 8'd3, 32'hDEADBEEF);
    chk32("b_wr3/word3", ram_flat[127:96], 32'hDEADBEEF);

    access("a_rd3", 1'b0, 1'b0, 8'd3, 32'h0);
    chk32("a_rd3/value", rdata_a, 32'hDEADBEEF);

    access("b_rd0", 1'b1, 1'b0, 8'd0, 32'h0);
    pair("pair1", 1'b0, 8'd3, 32'h0, 1'b0, 8'd3, 32'h0);
    pair("pair2", 1'b0, 8'd0, 32'h0, 1'b0, 8'd3, 32'h0);

    access("a_wr16", 1'b0, 1'b1, 8'd16, 32'h1);
    access("a_rd200", 1'b0, 1'b0, 8'd200, 32'h0);
    chk32("a_rd200/value", rdata_a, 32'h0);

    access("b_wr5", 1'b1, 1'b1, 8'd5, 32'h55);
    set_port(1'b1, 1'b1, 1'b1, 8'd5, 32'h77);
    @(negedge clk);
    chk1("rst_mid/busy", busy, 1'b1);
    reset = 1'b1;
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk1("rst_mid/ack_b", ack_b, 1'b0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk32("rst_mid/word5", ram_flat[191:160], 32'h0);
    chk_zero("rst_mid");

    for (int i = 0; i < RS; i++)
      access("load_wr", 1'b1, 1'b1, AW'(i), 32'(i + 1));
    for (int i = 0; i < RS; i++) begin
      access("load_rd", 1'b0, 1'b0, AW'(i), 32'h0);
      chk32("load_rd/value", rdata_a, 32'(i + 1));
    end
    chkw("load/image", ram_flat, image());

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(3) == 0)
        pair("rnd_pair",
             1'($urandom_range(1)), AW'($urandom_range(19)), $urandom,
             1'($urandom_range(1)), AW'($urandom_range(19)), $urandom);
      else
        access("rnd", 1'($urandom_range(1)), 1'($urandom_range(1)),
               AW'($urandom_range(19)), $urandom);
    end
    chkw("rnd/image", ram_flat, image());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
